// File: rtl/expr_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// expr_vector_sequencer_if
//   Stream bundle between the expression sequencer and its harness.
//   Operand input stream : in_valid, in_ready, in_vec
//   Result output stream : res_valid, res_ready, res_data, res_idx
//   master : harness side (drives operand stream, consumes results)
//   slave  : sequencer side (accepts operands, produces results)
// ---------------------------------------------------------------------------
interface expr_vector_sequencer_if #(
   parameter int OP_W  = 60,
   parameter int RES_W = 90,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_vec;
   logic             res_valid;
   logic             res_ready;
   logic [RES_W-1:0] res_data;
   logic [CNT_W-1:0] res_idx;

   modport master (
      output in_valid, in_vec, res_ready,
      input  in_ready, res_valid, res_data, res_idx
   );

   modport slave (
      input  in_valid, in_vec, res_ready,
      output in_ready, res_valid, res_data, res_idx
   );
endinterface

// File: rtl/expr_vector_sequencer.sv
// ---------------------------------------------------------------------------
// expr_vector_sequencer
//   Drives operand vectors (external stream or internal LFSR) onto a
//   combinational expression block, waits a settle window, captures the
//   result, streams it out and folds it into a 32-bit MISR signature.
// Ports
//   clk, rst      clock / synchronous active-high reset
//   start         begin a run (ignored while busy)
//   mode          0 = external vectors, 1 = internal LFSR (sampled with start)
//   num_vec       vectors per run (sampled with start)
//   seed          LFSR seed, 0 replaced by 1 (sampled with start)
//   bus           slave side of the operand / result streams
//   op_vec        registered operands {a0..a5,b0..b5}, a0 at MSB
//   expr_y        expression result
//   sig           MISR signature
//   busy, done    run status
// ---------------------------------------------------------------------------
module expr_vector_sequencer #(
   parameter int OP_W   = 60,
   parameter int RES_W  = 90,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode,
   input  logic [CNT_W-1:0]        num_vec,
   input  logic [OP_W-1:0]         seed,
   expr_vector_sequencer_if.slave  bus,
   output logic [OP_W-1:0]         op_vec,
   input  logic [RES_W-1:0]        expr_y,
   output logic [31:0]             sig,
   output logic                    busy,
   output logic                    done
);

   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_APPLY,
      ST_CAPTURE,
      ST_OUT,
      ST_DONE
   } state_t;

   state_t           state_reg;
   logic             mode_reg;
   logic [CNT_W-1:0] num_vec_reg;
   logic [OP_W-1:0]  lfsr_reg;
   logic [OP_W-1:0]  op_vec_reg;
   logic [SC_W-1:0]  settle_cnt_reg;
   logic             in_ready_reg;
   logic             res_valid_reg;
   logic [RES_W-1:0] res_data_reg;
   logic [CNT_W-1:0] res_idx_reg;
   logic [31:0]      sig_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [OP_W-1:0]  lfsr_next;
   logic [31:0]      fold;
   logic             misr_fb;
   logic [31:0]      sig_next;

   assign lfsr_next = {lfsr_reg[OP_W-2:0], lfsr_reg[OP_W-1] ^ lfsr_reg[OP_W-2]};

   // Fold the result into 32 bits: low word ^ middle word ^ zero-padded top.
   for (genvar gi = 0; gi < 32; gi++) begin : g_fold
      if (64 + gi < RES_W) begin : g_three
         assign fold[gi] = expr_y[gi] ^ expr_y[32+gi] ^ expr_y[64+gi];
      end else begin : g_two
         assign fold[gi] = expr_y[gi] ^ expr_y[32+gi];
      end
   end

   assign misr_fb  = sig_reg[31] ^ sig_reg[21] ^ sig_reg[1] ^ sig_reg[0];
   assign sig_next = {sig_reg[30:0], misr_fb} ^ fold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= 1'b0;
         num_vec_reg    <= '0;
         lfsr_reg       <= OP_W'(1);
         op_vec_reg     <= '0;
         settle_cnt_reg <= '0;
         in_ready_reg   <= 1'b0;
         res_valid_reg  <= 1'b0;
         res_data_reg   <= '0;
         res_idx_reg    <= '0;
         sig_reg        <= 32'hFFFF_FFFF;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mode_reg    <= mode;
                  num_vec_reg <= num_vec;
                  lfsr_reg    <= (seed == '0) ? OP_W'(1) : seed;
                  sig_reg     <= 32'hFFFF_FFFF;
                  res_idx_reg <= '0;
                  if (num_vec == '0) begin
                     // Empty run: finish immediately without touching operands.
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg    <= ST_LOAD;
                     done_reg     <= 1'b0;
                     busy_reg     <= 1'b1;
                     in_ready_reg <= ~mode;
                  end
               end
            end

            ST_LOAD: begin
               if (mode_reg) begin
                  op_vec_reg     <= lfsr_reg;
                  lfsr_reg       <= lfsr_next;
                  settle_cnt_reg <= '0;
                  state_reg      <= ST_APPLY;
               end else if (bus.in_valid && in_ready_reg) begin
                  op_vec_reg     <= bus.in_vec;
                  in_ready_reg   <= 1'b0;
                  settle_cnt_reg <= '0;
                  state_reg      <= ST_APPLY;
               end
            end

            ST_APPLY: begin
               // Operands are held while the expression settles.
               if (settle_cnt_reg == SETTLE_LAST) begin
                  state_reg <= ST_CAPTURE;
               end else begin
                  settle_cnt_reg <= settle_cnt_reg + SC_W'(1);
               end
            end

            ST_CAPTURE: begin
               // The only place the signature advances during a run, so each
               // vector contributes exactly once however long OUT stalls.
               res_data_reg  <= expr_y;
               res_valid_reg <= 1'b1;
               sig_reg       <= sig_next;
               state_reg     <= ST_OUT;
            end

            ST_OUT: begin
               if (bus.res_ready) begin
                  res_valid_reg <= 1'b0;
                  if (res_idx_reg == num_vec_reg - CNT_W'(1)) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end else begin
                     res_idx_reg  <= res_idx_reg + CNT_W'(1);
                     state_reg    <= ST_LOAD;
                     in_ready_reg <= ~mode_reg;
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.res_data  = res_data_reg;
   assign bus.res_idx   = res_idx_reg;
   assign op_vec        = op_vec_reg;
   assign sig           = sig_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_expr_vector_sequencer
//   Bench for expr_vector_sequencer. A stand-in expression model drives
//   expr_y from op_vec; expected results are queued when stimulus is
//   prepared and compared as the result stream hands them over.
// ---------------------------------------------------------------------------
module tb_expr_vector_sequencer;
   localparam int OP_W  = 60;
   localparam int RES_W = 90;
   localparam int CNT_W = 16;

   typedef struct {
      logic [RES_W-1:0] y;
      logic [CNT_W-1:0] idx;
      logic [OP_W-1:0]  op;
   } exp_t;

   typedef struct {
      logic             mode;
      logic [OP_W-1:0]  seed;
      logic [CNT_W-1:0] nvec;
      int               exp_results;
      logic             exp_done;
   } run_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             mode;
   logic [CNT_W-1:0] num_vec;
   logic [OP_W-1:0]  seed;
   logic [OP_W-1:0]  op_vec;
   logic [RES_W-1:0] expr_y;
   logic [31:0]      sig;
   logic             busy;
   logic             done;

   int               tests;
   int               failed;
   int               results_seen;
   logic [31:0]      model_sig;
   exp_t             exp_q[$];
   logic [OP_W-1:0]  in_q[$];

   expr_vector_sequencer_if #(.OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W)) bus ();

   expr_vector_sequencer #(.OP_W(OP_W), .RES_W(RES_W), .SETTLE(1), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .num_vec (num_vec),
      .seed    (seed),
      .bus     (bus),
      .op_vec  (op_vec),
      .expr_y  (expr_y),
      .sig     (sig),
      .busy    (busy),
      .done    (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [RES_W-1:0] model_f(input logic [OP_W-1:0] v);
      return {v[29:0], v} ^ 90'h1;
   endfunction

   function automatic logic [OP_W-1:0] lfsr_step(input logic [OP_W-1:0] l);
      return {l[58:0], l[59] ^ l[58]};
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [RES_W-1:0] y);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb} ^ (y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]});
   endfunction

   function automatic logic [OP_W-1:0] rand_vec();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[OP_W-1:0];
   endfunction

   assign expr_y = model_f(op_vec);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      tests++;
      if (act !== expv) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      failed++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   task automatic push_vec(input logic m, input logic [OP_W-1:0] v, input int i);
      exp_t e;
      if (!m) in_q.push_back(v);
      e.y = model_f(v);
      e.idx = CNT_W'(i);
      e.op = v;
      exp_q.push_back(e);
   endtask

   task automatic prep_run(input logic m, input logic [OP_W-1:0] s, input int n);
      logic [OP_W-1:0] l;
      l = (s == '0) ? OP_W'(1) : s;
      for (int i = 0; i < n; i++) begin
         if (m) begin
            push_vec(1'b1, l, i);
            l = lfsr_step(l);
         end else begin
            push_vec(1'b0, rand_vec(), i);
         end
      end
   endtask

   task automatic do_start(input logic m, input logic [CNT_W-1:0] n, input logic [OP_W-1:0] s);
      @(posedge clk); #1;
      model_sig = 32'hFFFF_FFFF;
      results_seen = 0;
      start = 1'b1;
      mode = m;
      num_vec = n;
      seed = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int k;
      k = 0;
      @(negedge clk);
      while (!done && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      if (!done) fail_now(name);
   endtask

   // Operand stream producer.
   initial begin : feeder
      logic hs;
      bus.in_valid = 1'b0;
      bus.in_vec = '0;
      forever begin
         @(negedge clk);
         hs = bus.in_valid && bus.in_ready && !rst;
         @(posedge clk); #1;
         if (hs && in_q.size() > 0) void'(in_q.pop_front());
         if (in_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_vec = in_q[0];
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   end

   // Result scoreboard: one line per result handshake.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.res_valid && bus.res_ready) begin
         results_seen++;
         if (exp_q.size() == 0) begin
            fail_now("res_unexpected");
         end else begin
            e = exp_q.pop_front();
            model_sig = misr(model_sig, e.y);
            $display("[TB] result idx=%0d op=%0h y=%0h sig=%08h", bus.res_idx, op_vec, bus.res_data, sig);
            chk("res_data", 128'(bus.res_data), 128'(e.y));
            chk("res_idx", 128'(bus.res_idx), 128'(e.idx));
            chk("op_vec", 128'(op_vec), 128'(e.op));
            chk("sig", 128'(sig), 128'(model_sig));
         end
      end
   end

   run_t runs[4];

   initial begin : main
      logic [OP_W-1:0] bp_seed;
      int k;
      tests = 0;
      failed = 0;
      results_seen = 0;
      model_sig = 32'hFFFF_FFFF;
      rst = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      num_vec = '0;
      seed = '0;
      bus.res_ready = 1'b1;

      runs[0] = '{mode: 1'b0, seed: 60'h0,               nvec: 16'd4, exp_results: 4, exp_done: 1'b1};
      runs[1] = '{mode: 1'b1, seed: 60'h0,               nvec: 16'd5, exp_results: 5, exp_done: 1'b1};
      runs[2] = '{mode: 1'b1, seed: 60'h8000_0000_0000_001, nvec: 16'd6, exp_results: 6, exp_done: 1'b1};
      runs[3] = '{mode: 1'b0, seed: 60'h0,               nvec: 16'd3, exp_results: 3, exp_done: 1'b1};

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_op_vec", 128'(op_vec), 128'(0));
      chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
      chk("rst_res_data", 128'(bus.res_data), 128'(0));
      chk("rst_res_idx", 128'(bus.res_idx), 128'(0));
      chk("rst_sig", 128'(sig), 128'(32'hFFFF_FFFF));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] reset checked");

      // External single vector of zero: y = 1, signature returns to all-ones.
      push_vec(1'b0, 60'h0, 0);
      do_start(1'b0, 16'd1, 60'h0);
      wait_done("ext1_done", 50);
      chk("ext1_sig", 128'(sig), 128'(32'hFFFF_FFFF));
      chk("ext1_done", 128'(done), 128'(1));
      chk("ext1_busy", 128'(busy), 128'(0));
      chk("ext1_count", 128'(results_seen), 128'(1));
      $display("[TB] ext single run sig=%08h", sig);

      // LFSR seed=1, three vectors: operands 1, 2, 4.
      push_vec(1'b1, 60'h1, 0);
      push_vec(1'b1, 60'h2, 1);
      push_vec(1'b1, 60'h4, 2);
      do_start(1'b1, 16'd3, 60'h1);
      wait_done("lfsr3_done", 100);
      chk("lfsr3_busy", 128'(busy), 128'(0));
      chk("lfsr3_count", 128'(results_seen), 128'(3));
      chk("lfsr3_sig", 128'(sig), 128'(model_sig));
      $display("[TB] lfsr seed=1 run sig=%08h", sig);

      // Table of runs.
      for (int r = 0; r < 4; r++) begin
         prep_run(runs[r].mode, runs[r].seed, int'(runs[r].nvec));
         do_start(runs[r].mode, runs[r].nvec, runs[r].seed);
         wait_done("tbl_done", 400);
         chk("tbl_count", 128'(results_seen), 128'(runs[r].exp_results));
         chk("tbl_done_flag", 128'(done), 128'(runs[r].exp_done));
         chk("tbl_busy", 128'(busy), 128'(0));
         chk("tbl_sig", 128'(sig), 128'(model_sig));
         chk("tbl_queue_empty", 128'(exp_q.size()), 128'(0));
         $display("[TB] table run %0d mode=%0d nvec=%0d sig=%08h", r, runs[r].mode, runs[r].nvec, sig);
      end

      // Backpressure: result held for five cycles, single MISR update.
      bp_seed = 60'h123_4567_89AB_CDEF;
      bus.res_ready = 1'b0;
      prep_run(1'b1, bp_seed, 2);
      do_start(1'b1, 16'd2, bp_seed);
      k = 0;
      @(negedge clk);
      while (!bus.res_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!bus.res_valid) fail_now("bp_res_valid_timeout");
      for (int c = 0; c < 5; c++) begin
         chk("bp_res_valid", 128'(bus.res_valid), 128'(1));
         chk("bp_res_data", 128'(bus.res_data), 128'(model_f(bp_seed)));
         chk("bp_sig", 128'(sig), 128'(misr(32'hFFFF_FFFF, model_f(bp_seed))));
         chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
         $display("[TB] backpressure cycle %0d sig=%08h", c, sig);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      wait_done("bp_done", 100);
      chk("bp_count", 128'(results_seen), 128'(2));
      chk("bp_final_sig", 128'(sig), 128'(model_sig));

      // num_vec = 0: done on the next cycle, no result.
      do_start(1'b0, 16'd0, 60'h0);
      @(negedge clk);
      chk("nv0_done", 128'(done), 128'(1));
      chk("nv0_busy", 128'(busy), 128'(0));
      chk("nv0_res_valid", 128'(bus.res_valid), 128'(0));
      chk("nv0_sig", 128'(sig), 128'(32'hFFFF_FFFF));
      repeat (3) @(negedge clk);
      chk("nv0_count", 128'(results_seen), 128'(0));
      $display("[TB] num_vec=0 run done=%0d", done);

      // start while busy is ignored.
      prep_run(1'b1, 60'h5A5, 2);
      do_start(1'b1, 16'd2, 60'h5A5);
      @(posedge clk); #1;
      start = 1'b1;
      mode = 1'b0;
      num_vec = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_start_busy", 128'(busy), 128'(1));
      wait_done("busy_start_done", 100);
      chk("busy_start_count", 128'(results_seen), 128'(2));
      chk("busy_start_sig", 128'(sig), 128'(model_sig));
      $display("[TB] start-while-busy run sig=%08h", sig);

      // Reset during APPLY, then a clean external run.
      prep_run(1'b1, 60'hABC, 3);
      do_start(1'b1, 16'd3, 60'hABC);
      @(posedge clk); #1;
      chk("mid_apply_op", 128'(op_vec), 128'(60'hABC));
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_res_valid", 128'(bus.res_valid), 128'(0));
      chk("mid_rst_res_idx", 128'(bus.res_idx), 128'(0));
      chk("mid_rst_sig", 128'(sig), 128'(32'hFFFF_FFFF));
      chk("mid_rst_op_vec", 128'(op_vec), 128'(0));
      chk("mid_rst_done", 128'(done), 128'(0));
      $display("[TB] reset during apply checked");
      prep_run(1'b0, 60'h0, 2);
      do_start(1'b0, 16'd2, 60'h0);
      wait_done("post_rst_done", 100);
      chk("post_rst_count", 128'(results_seen), 128'(2));
      chk("post_rst_sig", 128'(sig), 128'(model_sig));
      chk("post_rst_queue", 128'(exp_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
